// File: rtl/bit_reorder_pkg.sv
// bit_reorder_pkg: shared sizing helpers and drain-state encoding for bit_reorder.
package bit_reorder_pkg;

  // Symbols per reorder word.
  function automatic int unsigned sym_n(input int unsigned word_w, input int unsigned sym_w);
    return word_w / sym_w;
  endfunction

  // Index width clog2(n), never less than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_e;

endpackage

// File: rtl/bit_reorder_buf.sv
// bit_reorder_buf: one N-symbol word buffer with write port, stored mode bit,
// full flag and drain index.
//   clk, rst        : clock, async active-high reset
//   wr_en/wr_idx    : write strobe and fill index for this buffer
//   wr_data, wr_rev : symbol and mode (mode captured at fill index 0)
//   pop             : emit the head symbol this cycle
//   avail_c         : a complete word is readable now (includes the completing write)
//   head_c          : symbol at the current drain position (write bypassed)
//   last_c          : head is the final symbol of the word
module bit_reorder_buf
  import bit_reorder_pkg::*;
#(
  parameter int unsigned SYM_W = 2,
  parameter int unsigned N     = 4,
  parameter int unsigned IW    = idx_w(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_idx,
  input  logic [SYM_W-1:0] wr_data,
  input  logic             wr_rev,
  input  logic             pop,
  output logic             avail_c,
  output logic [SYM_W-1:0] head_c,
  output logic             last_c
);

  logic [SYM_W-1:0] mem [N];
  logic             rev_q;
  logic             full;
  logic [IW-1:0]    cnt;
  logic             complete;
  logic             rev_eff;
  logic [IW-1:0]    pos;

  // Head symbol is bypassed from the write port so a word can start
  // draining on the same edge its last symbol lands.
  always_comb begin
    complete = wr_en && (wr_idx == IW'(N - 1));
    rev_eff  = (wr_en && (wr_idx == '0)) ? wr_rev : rev_q;
    pos      = rev_eff ? (IW'(N - 1) - cnt) : cnt;
    head_c   = (wr_en && (wr_idx == pos)) ? wr_data : mem[pos];
    avail_c  = full | complete;
    last_c   = (cnt == IW'(N - 1));
  end

  // Symbol storage, no reset needed.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  // Mode, full flag and drain index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rev_q <= 1'b0;
      full  <= 1'b0;
      cnt   <= '0;
    end else begin
      if (wr_en && (wr_idx == '0)) rev_q <= wr_rev;
      full <= (full | complete) & ~(pop & last_c);
      if (pop) cnt <= last_c ? '0 : cnt + IW'(1);
    end
  end

endmodule

// File: rtl/bit_reorder.sv
// bit_reorder: ping-pong symbol reorder. Words of N=WORD_W/SYM_W symbols are
// emitted reversed (rev=1) or in arrival order (rev=0); partial words are dropped.
//   clk, rst          : clock, async active-high reset
//   axiiv, axiid, rev : input valid, symbol, reorder mode (sampled at word start)
//   axiov, axiod      : output valid, symbol (registered)
//   axiol             : last symbol of each output word
//   drop_cnt          : saturating count of discarded partial words
//                       (only with BIT_REORDER_DROP_CNT_EN defined)
module bit_reorder
  import bit_reorder_pkg::*;
#(
  parameter int unsigned SYM_W  = 2,
  parameter int unsigned WORD_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             axiiv,
  input  logic [SYM_W-1:0] axiid,
  input  logic             rev,
  output logic             axiov,
  output logic [SYM_W-1:0] axiod,
  output logic             axiol
`ifdef BIT_REORDER_DROP_CNT_EN
  ,
  output logic [15:0]      drop_cnt
`endif
);

  localparam int unsigned N  = sym_n(WORD_W, SYM_W);
  localparam int unsigned IW = idx_w(N);

  drain_state_e     state, state_d;
  logic [IW-1:0]    wr_idx, wr_idx_d;
  logic             wr_sel, wr_sel_d;
  logic             rd_sel, rd_sel_d;
  logic [1:0]       wr_en, pop, avail, last;
  logic [SYM_W-1:0] head [2];
  logic [SYM_W-1:0] axiod_d;
  logic             axiol_d;
  logic             drop;

  for (genvar g = 0; g < 2; g++) begin : g_buf
    bit_reorder_buf #(.SYM_W(SYM_W), .N(N), .IW(IW)) u_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en[g]),
      .wr_idx  (wr_idx),
      .wr_data (axiid),
      .wr_rev  (rev),
      .pop     (pop[g]),
      .avail_c (avail[g]),
      .head_c  (head[g]),
      .last_c  (last[g])
    );
  end

  // Fill/drain arbitration. Words complete and drain in strict alternation,
  // so rd_sel simply follows wr_sel one word behind.
  always_comb begin
    state_d  = IDLE;
    wr_idx_d = '0;
    wr_sel_d = wr_sel;
    rd_sel_d = rd_sel;
    wr_en    = 2'b00;
    pop      = 2'b00;
    axiod_d  = '0;
    axiol_d  = 1'b0;
    drop     = 1'b0;

    if (axiiv) begin
      wr_en[wr_sel] = 1'b1;
      if (wr_idx == IW'(N - 1)) begin
        wr_sel_d = ~wr_sel;
      end else begin
        wr_idx_d = wr_idx + IW'(1);
      end
    end else if (wr_idx != '0) begin
      drop = 1'b1;
    end

    if (avail[rd_sel]) begin
      state_d     = DRAIN;
      pop[rd_sel] = 1'b1;
      axiod_d     = head[rd_sel];
      axiol_d     = last[rd_sel];
      if (last[rd_sel]) rd_sel_d = ~rd_sel;
    end
  end

  // State and registered outputs; the DRAIN state is the output valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      wr_idx <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      axiod  <= '0;
      axiol  <= 1'b0;
    end else begin
      state  <= state_d;
      wr_idx <= wr_idx_d;
      wr_sel <= wr_sel_d;
      rd_sel <= rd_sel_d;
      axiod  <= axiod_d;
      axiol  <= axiol_d;
    end
  end

  assign axiov = (state == DRAIN);

`ifdef BIT_REORDER_DROP_CNT_EN
  // Saturating count of discarded partial words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_bit_reorder.sv
// tb_bit_reorder: randomized and directed stimulus against a queue-based
// stream model of the reorder function.
module tb_bit_reorder;

  localparam int unsigned SYM_W  = 2;
  localparam int unsigned WORD_W = 8;
  localparam int unsigned N      = WORD_W / SYM_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             axiiv;
  logic [SYM_W-1:0] axiid;
  logic             rev;
  logic             axiov;
  logic [SYM_W-1:0] axiod;
  logic             axiol;
`ifdef BIT_REORDER_DROP_CNT_EN
  logic [15:0]      drop_cnt;
`endif

  bit_reorder #(.SYM_W(SYM_W), .WORD_W(WORD_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .axiiv (axiiv),
    .axiid (axiid),
    .rev   (rev),
    .axiov (axiov),
    .axiod (axiod),
    .axiol (axiol)
`ifdef BIT_REORDER_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending partial word plus a stream of expected outputs.
  int unsigned m_word [$];
  logic        m_rev;
  int unsigned m_q [$];   // {last, symbol}
  int unsigned m_drops;

  task automatic model_reset();
    m_word.delete();
    m_q.delete();
    m_drops = 0;
    m_rev   = 1'b0;
  endtask

  task automatic model_accept(input logic v, input logic [SYM_W-1:0] d, input logic r);
    if (v) begin
      if (m_word.size() == 0) m_rev = r;
      m_word.push_back(int'(d));
      if (m_word.size() == N) begin
        for (int k = 0; k < N; k++) begin
          int unsigned s;
          s = m_rev ? m_word[N-1-k] : m_word[k];
          m_q.push_back(((k == N - 1) ? 256 : 0) + s);
        end
        m_word.delete();
      end
    end else if (m_word.size() != 0) begin
      m_word.delete();
      if (m_drops != 16'hFFFF) m_drops++;
    end
  endtask

  task automatic compare_out();
    int unsigned e;
    if (m_q.size() != 0) begin
      e = m_q.pop_front();
      chk("valid", 32'(axiov), 32'd1);
      chk("data",  32'(axiod), e & 32'hFF);
      chk("last",  32'(axiol), e >> 8);
    end else begin
      chk("idle_valid", 32'(axiov), 32'd0);
      chk("idle_data",  32'(axiod), 32'd0);
      chk("idle_last",  32'(axiol), 32'd0);
    end
`ifdef BIT_REORDER_DROP_CNT_EN
    chk("drop_cnt", 32'(drop_cnt), m_drops);
`endif
  endtask

  // One cycle: drive inputs, step the model at the edge, check just after.
  task automatic step(input logic v, input logic [SYM_W-1:0] d, input logic r);
    axiiv = v;
    axiid = d;
    rev   = r;
    @(posedge clk);
    #1;
    model_accept(v, d, r);
    compare_out();
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, '0, 1'b1);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    axiiv = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
  endtask

  logic [SYM_W-1:0] pat_a [8];
  logic [SYM_W-1:0] pat_b [4];

  initial begin
    rst   = 1'b1;
    axiiv = 1'b0;
    axiid = '0;
    rev   = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(axiov), 32'd0);
    chk("rst_data",  32'(axiod), 32'd0);
    chk("rst_last",  32'(axiol), 32'd0);
    rst = 1'b0;

    // Partial word of two symbols is discarded.
    step(1'b1, 2'b00, 1'b1);
    step(1'b1, 2'b01, 1'b1);
    idle(6);

    // Single word, reversed.
    pat_a = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b11, 2'b01, 2'b11, 2'b01};
    for (int i = 0; i < 4; i++) step(1'b1, pat_a[i], 1'b1);
    idle(6);

    // Two back-to-back words.
    for (int i = 0; i < 8; i++) step(1'b1, pat_a[i], 1'b1);
    idle(6);

    // 100 continuous words plus one extra symbol.
    pat_b = '{2'b00, 2'b01, 2'b11, 2'b01};
    for (int w = 0; w < 100; w++)
      for (int i = 0; i < 4; i++) step(1'b1, pat_b[i], 1'b1);
    step(1'b1, 2'b10, 1'b1);
    idle(6);

    // Passthrough with rev toggled mid-word: mode held from word start.
    for (int i = 0; i < 4; i++) step(1'b1, pat_b[i], (i >= 2) ? 1'b1 : 1'b0);
    idle(6);

    // Asynchronous reset during the third output symbol.
    for (int i = 0; i < 4; i++) step(1'b1, pat_b[i], 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(axiov), 32'd0);
    chk("async_rst_data",  32'(axiod), 32'd0);
    chk("async_rst_last",  32'(axiol), 32'd0);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, pat_b[i], 1'b1);
    idle(6);

    // Randomized traffic: gaps, random data and random mode.
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 7) != 0), SYM_W'($urandom), 1'($urandom));
    idle(8);
    chk("model_drained", 32'(m_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/bit_reorder.md
BIT_REORDER -- requirements
Module: bit_reorder

Interface
REQ-001 The block SHALL have parameter SYM_W, default 2, meaning symbol (lane) width in bits; legal values are 1, 2, 4 and 8.
REQ-002 The block SHALL have parameter WORD_W, default 8, meaning reorder word width in bits; it SHALL be a multiple of SYM_W and at most 64.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst, input, 1 bit, the asynchronous active-high reset.
REQ-006 The block SHALL have port axiiv, input, 1 bit, input symbol valid; deassertion ends the packet.
REQ-007 The block SHALL have port axiid, input, SYM_W bits, input symbol.
REQ-008 The block SHALL have port rev, input, 1 bit, reorder mode: 1 means reverse symbol order within each word, 0 means arrival-order passthrough.
REQ-009 The block SHALL have port axiov, output, 1 bit, output symbol valid.
REQ-010 The block SHALL have port axiod, output, SYM_W bits, output symbol.
REQ-011 The block SHALL have port axiol, output, 1 bit, high with the final symbol of each output word.

Function
REQ-012 The block SHALL define N = WORD_W/SYM_W symbols per word and hold two N-symbol word buffers used ping-pong.
REQ-013 Each accepted symbol (axiiv=1) SHALL be written at fill index wr_idx, which increments 0..N-1 and then wraps to 0.
REQ-014 rev SHALL be sampled when wr_idx=0 and axiiv=1, then held with that buffer for the whole word; changes to rev mid-word SHALL have no effect on that word.
REQ-015 On acceptance at wr_idx=N-1 the buffer SHALL be marked full and fill SHALL switch to the other buffer in the same cycle.
REQ-016 A full buffer SHALL drain one symbol per cycle, in index order N-1..0 when rev=1 and 0..N-1 when rev=0.
REQ-017 All outputs SHALL be registered; the first output symbol of a word SHALL appear on the cycle after that word's last symbol is accepted.
REQ-018 Continuous input SHALL produce continuous output with no bubbles; axiov SHALL remain high across word boundaries.
REQ-019 If axiiv falls while 0 < wr_idx < N, the partial word SHALL be discarded, wr_idx SHALL return to 0, and no symbols of that partial word SHALL be output.
REQ-020 A buffer already full or draining SHALL complete its drain regardless of axiiv.
REQ-021 Reassertion of axiiv while the other buffer is still draining SHALL be accepted without loss.
REQ-022 When no buffer is draining, axiov SHALL be 0, axiol SHALL be 0, and axiod SHALL hold 0.

Reset
REQ-023 Reset SHALL be asynchronous: it SHALL clear axiov, axiol, axiod, wr_idx, read index, buffer-full flags and the stored mode bits immediately.
REQ-024 Reset asserted mid-packet or mid-drain SHALL abandon all buffered data; the first accepted symbol after reset deassertion SHALL be at wr_idx=0.

Configuration
REQ-025 The macro BIT_REORDER_DROP_CNT_EN SHALL control a drop counter.
REQ-026 With BIT_REORDER_DROP_CNT_EN defined, the block SHALL add output drop_cnt[15:0], which increments by 1 per discarded partial word, saturates at 0xFFFF, and resets to 0.
REQ-027 Without BIT_REORDER_DROP_CNT_EN, port drop_cnt and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-028 Package bit_reorder_pkg SHALL hold the function computing N, the index-width function clog2(N), and the drain-state enum (IDLE, DRAIN).
REQ-029 Sub-module bit_reorder_buf SHALL implement one N-symbol buffer with write port, stored rev bit, full flag and drain index; the top SHALL instantiate two of them and arbitrate the ping-pong.

Verification (SYM_W=2, WORD_W=8, rev=1 unless stated)
REQ-030 Scenario: 2 symbols 00,01, then axiiv low -> axiov stays 0; with the macro defined, drop_cnt=1.
REQ-031 Scenario: 1 word of 00,01,00,01 -> one cycle later axiod=01,00,01,00 with axiov high for 4 cycles and axiol on the 4th.
REQ-032 Scenario: 2 words 00,01,00,01,11,01,11,01 back-to-back -> 8 contiguous outputs 01,00,01,00,01,11,01,11, axiol on outputs 4 and 8.
REQ-033 Scenario: 100 words of 00,01,11,01 plus 1 extra symbol -> 400 gapless outputs repeating 01,11,01,00; the extra symbol is dropped (drop_cnt=1).
REQ-034 Scenario: rev=0 for word 00,01,11,01, with rev toggled at fill index 2 -> output 00,01,11,01 (mode held).
REQ-035 Scenario: rst pulsed during the 3rd output symbol -> axiov=0 immediately (asynchronously); a following word outputs correctly.
